// File: rtl/roll_pkg.sv
// Shared types and defaults for the roll sequencer.
// Only the state encoding and the default value width live here.
package roll_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROLL = 2'd1,
    HOLD = 2'd2
  } roll_state_t;

  localparam int unsigned DEFAULT_VAL_W = 4;

endpackage

// File: rtl/roll_interval_timer.sv
// Interval timer for the roll: counts cycles up to the current interval, then
// restarts and lengthens the interval by a fixed step (saturating).
module roll_interval_timer #(
  parameter int unsigned INIT_INTERVAL = 2_500_000,
  parameter int unsigned INTERVAL_STEP = 1_250_000,
  parameter int unsigned CNT_W         = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic advance,
  output logic expire
);

  localparam logic [CNT_W-1:0] INIT_C = CNT_W'(INIT_INTERVAL);
  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(INTERVAL_STEP);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] interval;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] interval_next;

  // One extra bit catches the carry so the interval pins at all-ones.
  assign sum           = {1'b0, interval} + {1'b0, STEP_C};
  assign interval_next = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  assign expire        = (cnt == interval - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      interval <= '0;
    end else if (load) begin
      cnt      <= '0;
      interval <= INIT_C;
    end else if (advance) begin
      if (expire) begin
        cnt      <= '0;
        interval <= interval_next;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/roll_sequencer.sv
// Dice roll sequencer: samples the free-running random value at growing
// intervals after a start pulse, freezes the last sample and keeps the previous result.
module roll_sequencer
  import roll_pkg::*;
#(
  parameter int unsigned INIT_INTERVAL = 2_500_000,
  parameter int unsigned INTERVAL_STEP = 1_250_000,
  parameter int unsigned NUM_STEPS     = 16,
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned VAL_W         = DEFAULT_VAL_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic [VAL_W-1:0] i_rand,
  output logic [VAL_W-1:0] o_value,
  output logic [VAL_W-1:0] o_prev,
  output logic             o_update,
  output logic             o_busy,
  output logic             o_done
);

  localparam int unsigned      STEP_W    = $clog2(NUM_STEPS + 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

  roll_state_t       state;
  roll_state_t       state_next;
  logic [STEP_W-1:0] step;
  logic              load;
  logic              advance;
  logic              expire;
  logic              sample;
  logic              take_prev;

  roll_interval_timer #(
    .INIT_INTERVAL (INIT_INTERVAL),
    .INTERVAL_STEP (INTERVAL_STEP),
    .CNT_W         (CNT_W)
  ) u_timer (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .load    (load),
    .advance (advance),
    .expire  (expire)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  // A start pulse takes priority over stop and over a sample due that cycle.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    advance    = 1'b0;
    sample     = 1'b0;
    take_prev  = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          load       = 1'b1;
          state_next = ROLL;
        end
      end
      ROLL: begin
        if (i_start) begin
          load = 1'b1;
        end else begin
          advance = 1'b1;
          sample  = expire;
          if (i_stop || (expire && step == LAST_STEP)) state_next = HOLD;
        end
      end
      HOLD: begin
        if (i_start) begin
          load       = 1'b1;
          take_prev  = 1'b1;
          state_next = ROLL;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      step     <= '0;
      o_value  <= '0;
      o_prev   <= '0;
      o_update <= 1'b0;
    end else begin
      o_update <= sample;
      if (load)      step    <= '0;
      else if (sample) step  <= step + STEP_W'(1);
      if (sample)    o_value <= i_rand;
      if (take_prev) o_prev  <= o_value;
    end
  end

  assign o_busy = (state == ROLL);
  assign o_done = (state == HOLD);

endmodule
